// File: rtl/phase_pkg.sv
// Shared types and default sizing for the two-phase non-overlapping clock controller.
package phase_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DEAD_W_DEF      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StP1,
        StD12,
        StP2,
        StD21
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/phase_ctrl.sv
// Two-phase non-overlapping driver: synchronized PWM command steers phi1/phi2 with a
// guaranteed dead interval at every phase change, and counts completed phi2 pulses.
module phase_ctrl
    import phase_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DEAD_W      = DEAD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pwm_in,
    input  logic [DEAD_W-1:0] dead_time,
    output logic              phi1,
    output logic              phi2,
    output logic              in_dead,
    output logic [15:0]       cycle_cnt
);

    logic              pwm_s;
    state_e            state_q, state_d;
    logic [DEAD_W-1:0] dcnt_q, dcnt_d;
    logic [DEAD_W-1:0] dt_eff;
    logic              cnt_inc;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pwm_in),
        .q    (pwm_s)
    );

    // A zero dead time still yields one cycle of non-overlap.
    assign dt_eff = (dead_time == '0) ? DEAD_W'(1) : dead_time;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        cnt_inc = 1'b0;
        if (!en) begin
            state_d = StIdle;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = pwm_s ? StD12 : StD21;
                    dcnt_d  = dt_eff;
                end
                StP1: begin
                    if (pwm_s) begin
                        state_d = StD12;
                        dcnt_d  = dt_eff;
                    end
                end
                StP2: begin
                    if (!pwm_s) begin
                        state_d = StD21;
                        dcnt_d  = dt_eff;
                        cnt_inc = 1'b1;
                    end
                end
                StD12, StD21: begin
                    dcnt_d = dcnt_q - DEAD_W'(1);
                    // Interval always runs to completion; the target phase is chosen at expiry.
                    if (dcnt_q == DEAD_W'(1)) begin
                        state_d = pwm_s ? StP2 : StP1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dcnt_q    <= '0;
            phi1      <= 1'b0;
            phi2      <= 1'b0;
            in_dead   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            phi1    <= (state_d == StP1);
            phi2    <= (state_d == StP2);
            in_dead <= (state_d == StD12) || (state_d == StD21);
            if (cnt_inc) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
        end
    end

endmodule
